// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// multicycle_control_pkg: shared state encoding, opcodes and datapath select codes (rev 1.0).
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    ST_RESET     = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_READ  = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WRITE = 4'd6,
    ST_EXECUTE   = 4'd7,
    ST_R_WB      = 4'd8,
    ST_IMM_WB    = 4'd9,
    ST_BRANCH    = 4'd10,
    ST_JUMP      = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_opcode_decode.sv
`default_nettype none
// opcode_decode: maps the IR opcode field onto one-hot instruction class flags (rev 1.0).
module opcode_decode
  import multicycle_control_pkg::*;
(
  input  logic [5:0] opcode_i,
  output logic       is_r_o,
  output logic       is_lw_o,
  output logic       is_sw_o,
  output logic       is_beq_o,
  output logic       is_j_o,
  output logic       is_addi_o,
  output logic       is_illegal_o
);

  assign is_r_o       = (opcode_i == OP_R);
  assign is_lw_o      = (opcode_i == OP_LW);
  assign is_sw_o      = (opcode_i == OP_SW);
  assign is_beq_o     = (opcode_i == OP_BEQ);
  assign is_j_o       = (opcode_i == OP_J);
  assign is_addi_o    = (opcode_i == OP_ADDI);
  assign is_illegal_o = ~(is_r_o | is_lw_o | is_sw_o | is_beq_o | is_j_o | is_addi_o);

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// multicycle_control: main FSM sequencing the shared multicycle datapath, with a
// memory-ready wait counter and sticky timeout (rev 1.0).
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state_out
);

  localparam logic [8:0] WAIT_LIMIT = 9'(MEM_WAIT_MAX);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;

  logic w_is_r, w_is_lw, w_is_sw, w_is_beq, w_is_j, w_is_addi, w_is_illegal;
  logic w_mem_state, w_stall, w_wait_expired;

  // zero only gates the external PC load alongside PCWriteCond.
  logic unused_zero;
  assign unused_zero = zero;

  opcode_decode u_opcode_decode (
    .opcode_i     (opcode),
    .is_r_o       (w_is_r),
    .is_lw_o      (w_is_lw),
    .is_sw_o      (w_is_sw),
    .is_beq_o     (w_is_beq),
    .is_j_o       (w_is_j),
    .is_addi_o    (w_is_addi),
    .is_illegal_o (w_is_illegal)
  );

  assign w_mem_state    = (state_q == ST_FETCH) || (state_q == ST_MEM_READ) ||
                          (state_q == ST_MEM_WRITE);
  assign w_stall        = w_mem_state && !mem_ready;
  assign w_wait_expired = ({1'b0, wait_cnt_q} + 9'd1) >= WAIT_LIMIT;

  assign state_out   = state_q;
  assign mem_timeout = timeout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RESET;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = '0;
    timeout_d   = timeout_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUOp       = ALUOP_ADD;
    ALUSrcB     = SRCB_REG;
    illegal_op  = 1'b0;

    // The counter runs only while a memory state is stalled; any other cycle clears it.
    if (w_stall) begin
      if (w_wait_expired) timeout_d = 1'b1;
      else wait_cnt_d = wait_cnt_q + 8'd1;
    end

    case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ALUSrcB = SRCB_IMM_SH2;
        if (w_is_lw || w_is_sw)       state_d = ST_MEM_ADDR;
        else if (w_is_r || w_is_addi) state_d = ST_EXECUTE;
        else if (w_is_beq)            state_d = ST_BRANCH;
        else if (w_is_j)              state_d = ST_JUMP;
        else begin
          illegal_op = w_is_illegal;
          state_d    = ST_FETCH;
        end
      end
      ST_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = w_is_sw ? ST_MEM_WRITE : ST_MEM_READ;
      end
      ST_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready)           state_d = ST_MEM_WB;
        else if (w_wait_expired) state_d = ST_FETCH;
      end
      ST_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready || w_wait_expired) state_d = ST_FETCH;
      end
      ST_EXECUTE: begin
        ALUSrcA = 1'b1;
        if (w_is_addi) begin
          ALUSrcB = SRCB_IMM;
          state_d = ST_IMM_WB;
        end else begin
          ALUOp   = ALUOP_FUNCT;
          state_d = ST_R_WB;
        end
      end
      ST_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_IMM_WB: begin
        RegWrite = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_BRANCH;
        state_d     = ST_FETCH;
      end
      ST_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
        state_d  = ST_FETCH;
      end
      default: state_d = ST_RESET;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// tb_multicycle_control: directed and randomized instruction streams checked cycle by
// cycle against an instruction-level reference of the control sequence.
module tb_multicycle_control;

  localparam int WMAX = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [3:0] S_RESET = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,  S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_READ = 4'd4, S_MEM_WB = 4'd5, S_MEM_WRITE = 4'd6, S_EXECUTE = 4'd7;
  localparam logic [3:0] S_R_WB = 4'd8, S_IMM_WB = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic       RegWrite, RegDst, ALUSrcA, illegal_op, mem_timeout;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic [3:0] state_out;
  logic [17:0] ctl;

  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite,
                RegDst, ALUSrcA, PCSource, ALUOp, ALUSrcB, illegal_op, mem_timeout};

  always #5 clk = ~clk;

  multicycle_control #(.MEM_WAIT_MAX(WMAX)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcB(ALUSrcB), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
    .state_out(state_out)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       mr;
  } step_t;

  step_t plan[$];
  int    n_pass = 0;
  int    n_fail = 0;
  int    n_total = 0;
  int    wait_run = 0;
  logic  exp_to = 1'b0;

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic legal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  endfunction

  // Expected control word for one cycle, straight from the per-state output table.
  function automatic logic [17:0] exp_ctrl(input logic [3:0] st, input logic [5:0] op,
                                           input logic mr, input logic to);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, srca, ill;
    logic [1:0] pcs, aop, srcb;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, srca, ill} = '0;
    pcs = 2'b00; aop = 2'b00; srcb = 2'b00;
    case (st)
      S_FETCH:     begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      S_DECODE:    begin srcb = 2'b11; ill = !legal(op); end
      S_MEM_ADDR:  begin srca = 1; srcb = 2'b10; end
      S_MEM_READ:  begin mrd = 1; iord = 1; end
      S_MEM_WB:    begin rw = 1; m2r = 1; end
      S_MEM_WRITE: begin mwr = 1; iord = 1; end
      S_EXECUTE:   begin srca = 1; if (op == OP_ADDI) srcb = 2'b10; else aop = 2'b10; end
      S_R_WB:      begin rw = 1; rdst = 1; end
      S_IMM_WB:    rw = 1;
      S_BRANCH:    begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      S_JUMP:      begin pcw = 1; pcs = 2'b10; end
      default:     ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, srca, pcs, aop, srcb, ill, to};
  endfunction

  // Expected state walk of one instruction; fs/ms are stall cycles before mem_ready.
  task automatic build(input logic [5:0] op, input int fs, input int ms);
    logic [3:0] s;
    plan.delete();
    repeat (fs) plan.push_back({S_FETCH, 1'b0});
    plan.push_back({S_FETCH, 1'b1});
    plan.push_back({S_DECODE, 1'($urandom_range(0, 1))});
    case (op)
      OP_LW, OP_SW: begin
        plan.push_back({S_MEM_ADDR, 1'($urandom_range(0, 1))});
        s = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        if (ms >= WMAX) begin
          repeat (WMAX) plan.push_back({s, 1'b0});
        end else begin
          repeat (ms) plan.push_back({s, 1'b0});
          plan.push_back({s, 1'b1});
          if (op == OP_LW) plan.push_back({S_MEM_WB, 1'($urandom_range(0, 1))});
        end
      end
      OP_R: begin
        plan.push_back({S_EXECUTE, 1'($urandom_range(0, 1))});
        plan.push_back({S_R_WB, 1'($urandom_range(0, 1))});
      end
      OP_ADDI: begin
        plan.push_back({S_EXECUTE, 1'($urandom_range(0, 1))});
        plan.push_back({S_IMM_WB, 1'($urandom_range(0, 1))});
      end
      OP_BEQ: plan.push_back({S_BRANCH, 1'($urandom_range(0, 1))});
      OP_J:   plan.push_back({S_JUMP, 1'($urandom_range(0, 1))});
      default: ;
    endcase
  endtask

  // Entered at posedge+1; each step drives mem_ready, checks at posedge+2, then advances.
  task automatic play(input logic [5:0] op, input string tag);
    opcode = op;
    foreach (plan[i]) begin
      mem_ready = plan[i].mr;
      #1;
      chk({tag, "/state"}, 18'(state_out), 18'(plan[i].st));
      chk({tag, "/ctl"}, ctl, exp_ctrl(plan[i].st, op, plan[i].mr, exp_to));
      if ((plan[i].st inside {S_FETCH, S_MEM_READ, S_MEM_WRITE}) && !plan[i].mr) begin
        wait_run++;
        if (wait_run == WMAX) begin
          exp_to   = 1'b1;
          wait_run = 0;
        end
      end else begin
        wait_run = 0;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run(input logic [5:0] op, input int fs, input int ms, input string tag);
    build(op, fs, ms);
    play(op, tag);
  endtask

  function automatic logic [5:0] pick();
    int unsigned sel;
    sel = $urandom_range(0, 6);
    case (sel)
      0: return OP_R;
      1: return OP_LW;
      2: return OP_SW;
      3: return OP_BEQ;
      4: return OP_J;
      5: return OP_ADDI;
      default: return 6'($urandom());
    endcase
  endfunction

  initial begin
    reset = 1'b1; mem_ready = 1'b0; opcode = 6'd0; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/state", 18'(state_out), 18'(S_RESET));
    chk("reset/ctl", ctl, 18'd0);
    reset = 1'b0;
    #1;
    chk("release/state", 18'(state_out), 18'(S_RESET));
    @(posedge clk);
    #1;

    run(OP_LW, 0, 0, "lw");
    zero = 1'b1;
    run(OP_BEQ, 0, 0, "beq");
    run(OP_R, 3, 0, "r_fstall");
    run(6'b111111, 0, 0, "illegal");
    run(OP_SW, 0, 0, "sw");
    run(OP_ADDI, 0, 0, "addi");
    run(OP_J, 0, 0, "j");
    run(OP_LW, 1, 2, "lw_stall");
    run(OP_SW, 0, 3, "sw_stall");

    for (int k = 0; k < 25; k++) begin
      zero = 1'($urandom_range(0, 1));
      run(pick(), $urandom_range(0, 3), $urandom_range(0, 3), "rand");
    end

    run(OP_SW, 0, WMAX, "sw_timeout");
    run(OP_R, 6, 0, "fetch_timeout");
    for (int k = 0; k < 10; k++) begin
      run(pick(), $urandom_range(0, 5), $urandom_range(0, 5), "rand_to");
    end

    build(OP_SW, 0, 0);
    void'(plan.pop_back());
    play(OP_SW, "rstmid");
    mem_ready = 1'b0;
    #1;
    chk("rstmid/memwrite", ctl, exp_ctrl(S_MEM_WRITE, OP_SW, 1'b0, exp_to));
    reset    = 1'b1;
    exp_to   = 1'b0;
    wait_run = 0;
    #1;
    chk("rstmid/state", 18'(state_out), 18'(S_RESET));
    chk("rstmid/ctl", ctl, 18'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rstmid/hold", 18'(state_out), 18'(S_RESET));
    @(posedge clk);
    #1;
    run(OP_J, 1, 0, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Main control state machine for the multicycle CPU. It sequences the shared datapath (PC, IR, register file, ALU, single memory port, and the sign-extend and jump-address units) through fetch, decode, execute, memory and write-back steps for each instruction. It waits on a memory-ready handshake and emits per-cycle datapath select and enable signals.

## Interface
- `MEM_WAIT_MAX`, default 255: wait-cycle limit per memory access before `mem_timeout` is raised.
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high; forces state RESET.
- `opcode` input 6: IR[31:26], valid from DECODE onward.
- `zero` input 1: ALU zero flag, sampled in BRANCH.
- `mem_ready` input 1: memory has completed the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegWrite`, `RegDst`, `ALUSrcA` output 1 each: standard multicycle datapath controls.
- `PCSource` output 2: 00 ALU result (PC+4), 01 ALUOut (branch target), 10 jump address.
- `ALUOp` output 2: 00 add, 01 subtract, 10 funct-decoded.
- `ALUSrcB` output 2: 00 reg B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left 2.
- `illegal_op` output 1: one-cycle pulse on an unknown opcode.
- `mem_timeout` output 1: sticky until reset.
- `state_out` output 4: current state, for debug.

## Operation
- States: RESET, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, R_WB, IMM_WB, BRANCH, JUMP.
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, J=000010, ADDI=001000.
- RESET: all outputs 0. Moves to FETCH on the first clock after `reset` deasserts.
- FETCH:
  - Asserts `MemRead=1`, `IorD=0`, `ALUSrcA=0`, `ALUSrcB=01`, `ALUOp=00`, `PCSource=00`.
  - `IRWrite` and `PCWrite` assert only in the cycle where `mem_ready=1`; the state then moves to DECODE.
  - Otherwise the state holds.
- DECODE: `ALUSrcA=0`, `ALUSrcB=11`, `ALUOp=00` (branch target into ALUOut). Next state by opcode:
  - LW or SW → MEM_ADDR
  - R → EXECUTE
  - ADDI → EXECUTE
  - BEQ → BRANCH
  - J → JUMP
  - any other opcode → FETCH, with `illegal_op` pulsed for this cycle.
- MEM_ADDR: `ALUSrcA=1`, `ALUSrcB=10`, `ALUOp=00`. Goes to MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: `MemRead=1`, `IorD=1`. Holds until `mem_ready`, then goes to MEM_WB.
- MEM_WB: `RegWrite=1`, `MemtoReg=1`, `RegDst=0`. Goes to FETCH.
- MEM_WRITE: `MemWrite=1`, `IorD=1`. Holds until `mem_ready`, then goes to FETCH.
- EXECUTE:
  - R-type: `ALUSrcA=1`, `ALUSrcB=00`, `ALUOp=10`, then R_WB.
  - ADDI: `ALUSrcA=1`, `ALUSrcB=10`, `ALUOp=00`, then IMM_WB.
- R_WB: `RegWrite=1`, `RegDst=1`, `MemtoReg=0`. Goes to FETCH.
- IMM_WB: `RegWrite=1`, `RegDst=0`, `MemtoReg=0`. Goes to FETCH.
- BRANCH: `ALUSrcA=1`, `ALUSrcB=00`, `ALUOp=01`, `PCWriteCond=1`, `PCSource=01`. Goes to FETCH. The PC is loaded externally only when `zero=1`.
- JUMP: `PCWrite=1`, `PCSource=10`. Goes to FETCH.
- Wait counter:
  - 8-bit, cleared on entry to any memory state, increments each cycle spent waiting.
  - When it reaches `MEM_WAIT_MAX`, `mem_timeout` sets and the FSM returns to FETCH without writing.
  - The PC is not incremented on a FETCH timeout; the fetch retries.
- In every state, any output not listed is 0.

## Timing
- Outputs are decoded from the registered state. The only exceptions are `IRWrite` and `PCWrite` in FETCH, which are qualified combinationally by `mem_ready`.
- Instruction latency with `mem_ready` tied high:
  - LW: 5 cycles
  - SW: 4 cycles
  - R-type and ADDI: 4 cycles
  - BEQ and J: 3 cycles
- Each memory stall adds one cycle.
- `reset` asserted mid-instruction:
  - state goes to RESET immediately, all outputs drop to 0 in the same cycle;
  - the wait counter and `mem_timeout` clear.
- If `mem_ready` is high on the entry cycle of a memory state, the state advances on the next edge with zero wait.

## Structure
- Shared package holds:
  - the state encoding localparams (4-bit, RESET=0);
  - the opcode constants;
  - the `PCSource`, `ALUOp` and `ALUSrcB` code constants.
- One sub-module, `opcode_decode`: combinational, maps `opcode` to one-hot class signals (is_r, is_lw, is_sw, is_beq, is_j, is_addi, is_illegal).
- The FSM register, next-state logic, output decode and wait counter live in `multicycle_control`.

## Test plan
- Reset release, `mem_ready=1`, opcode LW → `state_out` sequence 1,2,3,4,5,1. `RegWrite`=1 only in MEM_WB, `MemtoReg`=1 there.
- Opcode BEQ, `zero=1` → BRANCH shows `PCWriteCond=1`, `PCSource=01`, `ALUOp=01`; 3 cycles total.
- FETCH with `mem_ready` low for 3 cycles → `IRWrite`=0 for 3 cycles, then 1 for exactly one cycle; total fetch length 4 cycles.
- Opcode 111111 → `illegal_op` high for one cycle in DECODE, next state FETCH, no `RegWrite` or `MemWrite`.
- `MEM_WAIT_MAX=4`, SW with `mem_ready` held low → `mem_timeout` sets after 4 wait cycles, returns to FETCH, and stays set until `reset`.
- `reset` asserted during MEM_WRITE → `MemWrite` drops to 0 in the same cycle, `state_out=0`, then FETCH one cycle after release.
